// File: rtl/alu_entry_sequencer_if.sv
// Operand/opcode/launch handshake between the entry sequencer and the 4-bit ALU.
interface alu_entry_sequencer_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic       alu_start;
  logic       alu_done;
  logic [3:0] alu_result;

  modport master (
    output alu_a,
    output alu_b,
    output alu_op,
    output alu_start,
    input  alu_done,
    input  alu_result
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_op,
    input  alu_start,
    output alu_done,
    output alu_result
  );
endinterface

// File: rtl/alu_entry_sequencer.sv
// Pushbutton-driven entry of A, B and opcode, ALU launch with timeout,
// and selection of the value shown on the hex display.
module alu_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   din,
  input  logic                         key_n,
  alu_entry_sequencer_if.master        alu,
  output logic [3:0]                   aluout,
  output logic [2:0]                   stage,
  output logic                         err
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] GET_A  = 3'd0;
  localparam logic [2:0] GET_B  = 3'd1;
  localparam logic [2:0] GET_OP = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] SHOW   = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [DB_W-1:0] hi_cnt_q, hi_cnt_d;
  logic            armed_q, armed_d;
  logic            press_s;

  logic [2:0]  state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic        start_q, start_d;
  logic [3:0]  result_q, result_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic [3:0]  aluout_q, aluout_d;

  // Debouncer: stable level (1 = released) flips after DEBOUNCE_CYCLES of disagreement.
  // Presses are only reported once a full released interval has been seen since reset.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    press_s  = 1'b0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        db_cnt_d = '0;
        press_s  = stable_q & armed_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end

    armed_d  = armed_q;
    hi_cnt_d = '0;
    if (sync2_q) begin
      if (hi_cnt_q == DB_LAST) begin
        armed_d  = 1'b1;
        hi_cnt_d = hi_cnt_q;
      end else begin
        hi_cnt_d = hi_cnt_q + DB_W'(1);
      end
    end else begin
      hi_cnt_d = '0;
    end
  end

  // Entry/launch state machine and captured operands.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    start_d  = 1'b0;
    result_d = result_q;
    timer_d  = timer_q;
    err_d    = err_q;
    case (state_q)
      GET_A: begin
        if (press_s) begin
          a_d     = din;
          state_d = GET_B;
        end else begin
          state_d = GET_A;
        end
      end
      GET_B: begin
        if (press_s) begin
          b_d     = din;
          state_d = GET_OP;
        end else begin
          state_d = GET_B;
        end
      end
      GET_OP: begin
        if (press_s) begin
          op_d    = din[1:0];
          timer_d = 16'd0;
          start_d = 1'b1;
          state_d = RUN;
        end else begin
          state_d = GET_OP;
        end
      end
      RUN: begin
        // A done coinciding with the last timer cycle still counts as success.
        if (!start_q && alu.alu_done) begin
          result_d = alu.alu_result;
          state_d  = SHOW;
        end else if (timer_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SHOW: begin
        if (press_s) begin
          state_d = GET_A;
        end else begin
          state_d = SHOW;
        end
      end
      ERR: begin
        if (press_s) begin
          err_d   = 1'b0;
          state_d = GET_A;
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        err_d   = 1'b0;
        state_d = GET_A;
      end
    endcase
  end

  // Display value follows the state being entered so it lines up with stage.
  always_comb begin
    aluout_d = aluout_q;
    case (state_d)
      GET_A, GET_B: aluout_d = din;
      GET_OP:       aluout_d = {2'b00, din[1:0]};
      RUN:          aluout_d = aluout_q;
      SHOW:         aluout_d = result_d;
      ERR:          aluout_d = 4'hE;
      default:      aluout_d = 4'h0;
    endcase
  end

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b1;
      db_cnt_q <= '0;
      hi_cnt_q <= '0;
      armed_q  <= 1'b0;
      state_q  <= GET_A;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      op_q     <= 2'b00;
      start_q  <= 1'b0;
      result_q <= 4'h0;
      timer_q  <= 16'd0;
      err_q    <= 1'b0;
      aluout_q <= 4'h0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      hi_cnt_q <= hi_cnt_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      start_q  <= start_d;
      result_q <= result_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      aluout_q <= aluout_d;
    end
  end

  assign alu.alu_a     = a_q;
  assign alu.alu_b     = b_q;
  assign alu.alu_op    = op_q;
  assign alu.alu_start = start_q;
  assign aluout        = aluout_q;
  assign stage         = state_q;
  assign err           = err_q;

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Self-checking bench for alu_entry_sequencer: table vectors, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_alu_entry_sequencer;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       key_n;
  logic [3:0] aluout;
  logic [2:0] stage;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_entry_sequencer_if alu_if();

  alu_entry_sequencer #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .key_n  (key_n),
    .alu    (alu_if),
    .aluout (aluout),
    .stage  (stage),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    int         done_cyc;
    logic [3:0] res;
    logic [2:0] exp_stage;
    logic [3:0] exp_out;
    logic       exp_err;
    int         exp_end;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release for 8 cycles with junk on din, then hold low until the press edge.
  task automatic press(input logic [3:0] v);
    key_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = ~v;
      tick();
    end
    din   = v;
    key_n = 1'b0;
    repeat (6) tick();
    key_n = 1'b1;
  endtask

  // Outcome from the rules: first done from RUN cycle 2 through TO wins, else timeout.
  function automatic vec_t predict(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                                   input int k, input logic [3:0] res);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.done_cyc = k; v.res = res;
    if (k >= 2 && k <= TO) begin
      v.exp_stage = 3'd4; v.exp_out = res; v.exp_err = 1'b0; v.exp_end = k;
    end else begin
      v.exp_stage = 3'd5; v.exp_out = 4'hE; v.exp_err = 1'b1; v.exp_end = TO;
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input bit poke);
    logic [1:0] hi;
    logic [3:0] nxt;
    press(v.a);
    chk("stage_get_b", 32'(stage), 32'd1);
    chk("alu_a", 32'(alu_if.alu_a), 32'(v.a));
    press(v.b);
    chk("stage_get_op", 32'(stage), 32'd2);
    chk("alu_b", 32'(alu_if.alu_b), 32'(v.b));
    hi = 2'($urandom_range(0, 3));
    press({hi, v.op});
    chk("stage_run", 32'(stage), 32'd3);
    chk("alu_op", 32'(alu_if.alu_op), 32'(v.op));
    chk("aluout_op", 32'(aluout), 32'(v.op));
    for (int c = 1; c <= v.exp_end; c++) begin
      chk("alu_start", 32'(alu_if.alu_start), (c == 1) ? 32'd1 : 32'd0);
      alu_if.alu_done   = (c == v.done_cyc);
      alu_if.alu_result = (c == v.done_cyc) ? v.res : 4'($urandom);
      din = 4'($urandom);
      tick();
      alu_if.alu_done = 1'b0;
      if (c < v.exp_end) chk("run_hold", 32'(stage), 32'd3);
      else               chk("run_exit", 32'(stage), 32'(v.exp_stage));
    end
    chk("aluout_end", 32'(aluout), 32'(v.exp_out));
    chk("err_end", 32'(err), 32'(v.exp_err));
    chk("start_end", 32'(alu_if.alu_start), 32'd0);
    if (poke) begin
      alu_if.alu_done   = 1'b1;
      alu_if.alu_result = ~v.exp_out;
      tick();
      alu_if.alu_done = 1'b0;
      chk("poke_stage", 32'(stage), 32'(v.exp_stage));
      chk("poke_aluout", 32'(aluout), 32'(v.exp_out));
    end
    nxt = 4'($urandom);
    press(nxt);
    chk("back_stage", 32'(stage), 32'd0);
    chk("back_err", 32'(err), 32'd0);
    chk("back_aluout", 32'(aluout), 32'(nxt));
    chk("keep_a", 32'(alu_if.alu_a), 32'(v.a));
    chk("keep_b", 32'(alu_if.alu_b), 32'(v.b));
    chk("keep_op", 32'(alu_if.alu_op), 32'(v.op));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[5];
    vec_t rv;
    tbl[0] = '{a:4'h5, b:4'h3, op:2'd2, done_cyc:3,  res:4'h8, exp_stage:3'd4, exp_out:4'h8, exp_err:1'b0, exp_end:3};
    tbl[1] = '{a:4'hF, b:4'h0, op:2'd1, done_cyc:16, res:4'hA, exp_stage:3'd4, exp_out:4'hA, exp_err:1'b0, exp_end:16};
    tbl[2] = '{a:4'h1, b:4'h2, op:2'd3, done_cyc:0,  res:4'h0, exp_stage:3'd5, exp_out:4'hE, exp_err:1'b1, exp_end:16};
    tbl[3] = '{a:4'h7, b:4'h7, op:2'd0, done_cyc:1,  res:4'h4, exp_stage:3'd5, exp_out:4'hE, exp_err:1'b1, exp_end:16};
    tbl[4] = '{a:4'h0, b:4'hF, op:2'd3, done_cyc:2,  res:4'h5, exp_stage:3'd4, exp_out:4'h5, exp_err:1'b0, exp_end:2};

    alu_if.alu_done   = 1'b0;
    alu_if.alu_result = 4'h0;
    key_n = 1'b0;
    din   = 4'h9;
    do_reset();
    tick();
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_aluout_a", 32'(alu_if.alu_a), 32'd0);
    chk("rst_b", 32'(alu_if.alu_b), 32'd0);
    chk("rst_op", 32'(alu_if.alu_op), 32'd0);
    chk("rst_start", 32'(alu_if.alu_start), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Key held through reset, short release, press again: nothing accepted.
    repeat (8) tick();
    chk("held_no_press", 32'(stage), 32'd0);
    key_n = 1'b1; repeat (3) tick();
    key_n = 1'b0; repeat (8) tick();
    chk("short_release_no_press", 32'(stage), 32'd0);
    key_n = 1'b1; repeat (8) tick();

    // Bounce rejection, then one clean press with exact latency.
    key_n = 1'b0; repeat (2) tick();
    key_n = 1'b1; repeat (1) tick();
    key_n = 1'b0; repeat (3) tick();
    key_n = 1'b1; repeat (10) tick();
    chk("bounce_stage", 32'(stage), 32'd0);
    key_n = 1'b0; din = 4'h6;
    repeat (5) tick();
    chk("press_lat5", 32'(stage), 32'd0);
    tick();
    chk("press_lat6", 32'(stage), 32'd1);
    chk("press_a", 32'(alu_if.alu_a), 32'h6);
    tick();
    chk("single_pulse", 32'(stage), 32'd1);
    key_n = 1'b1;
    do_reset();
    chk("rst2_stage", 32'(stage), 32'd0);

    // done in GET_A must be ignored.
    repeat (8) tick();
    alu_if.alu_done = 1'b1; alu_if.alu_result = 4'h7;
    tick();
    alu_if.alu_done = 1'b0;
    chk("done_in_get_a", 32'(stage), 32'd0);

    for (int i = 0; i < 5; i++) run_txn(tbl[i], 1'b1);

    // Reset in the middle of RUN (timer = 7).
    press(4'h9); press(4'h4); press(4'h1);
    repeat (7) tick();
    chk("mid_run_stage", 32'(stage), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_stage", 32'(stage), 32'd0);
    chk("midrst_start", 32'(alu_if.alu_start), 32'd0);
    chk("midrst_a", 32'(alu_if.alu_a), 32'd0);
    chk("midrst_b", 32'(alu_if.alu_b), 32'd0);
    chk("midrst_op", 32'(alu_if.alu_op), 32'd0);
    chk("midrst_aluout", 32'(aluout), 32'd0);
    run_txn(tbl[0], 1'b0);

    for (int i = 0; i < 20; i++) begin
      rv = predict(4'($urandom), 4'($urandom), 2'($urandom), $urandom_range(1, 20), 4'($urandom));
      run_txn(rv, (i % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_entry_sequencer.md
Name: alu_entry_sequencer

Overview:
- Operator-facing sequencer for the 4-bit ALU on the board.
- Collects operand A, operand B and a 2-bit opcode from switches, one debounced pushbutton press per step.
- Launches the ALU with a start/done handshake and a timeout.
- Drives the 4-bit value shown on the hex display through the existing 7-segment converter (aluout → DHEX).

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required to accept a key level change; board builds override to 1000000.
- TIMEOUT_CYCLES, 16: maximum RUN cycles to wait for alu_done before entering ERR; legal range 2..65535.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- din  in  4  switch value: operand, or opcode in din[1:0].
- key_n  in  1  raw pushbutton, active-low, asynchronous, bouncy.
- alu_a  out  4  registered operand A to the ALU.
- alu_b  out  4  registered operand B to the ALU.
- alu_op  out  2  registered opcode to the ALU.
- alu_start  out  1  single-cycle launch pulse.
- alu_done  in  1  ALU completion strobe, one cycle.
- alu_result  in  4  ALU result, valid while alu_done=1.
- aluout  out  4  registered value for the hex converter.
- stage  out  3  current state code.
- err  out  1  timeout flag.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - alu_a, alu_b, alu_op, alu_start, aluout, err, result register and timer all clear to 0.
  - stage goes to GET_A (0).
  - Synchronizer and debouncer clear, and any pending press is discarded.
  - This applies equally mid-operation, in any state.
- Key path:
  - key_n passes through a 2-FF synchronizer.
  - The debouncer holds a stable level initialised to "released" and counts consecutive cycles in which the synchronized input differs from that level. Any agreeing cycle resets the count.
  - When the count reaches DEBOUNCE_CYCLES, the stable level flips.
  - A released→pressed flip emits a one-cycle press pulse.
  - Worst-case press latency is 2 + DEBOUNCE_CYCLES cycles after the key_n fall.
  - One physical press produces exactly one pulse.
  - A key held low through reset release produces no press until it is stably released and then pressed again. The debouncer must be forced to "released" only after it has seen DEBOUNCE_CYCLES of high.
- State codes: GET_A=0, GET_B=1, GET_OP=2, RUN=3, SHOW=4, ERR=5. Codes 6-7 are illegal and return to GET_A on the next cycle.
- aluout is registered (1-cycle latency) and selected by state:
  - GET_A and GET_B: din.
  - GET_OP: {2'b00, din[1:0]}.
  - RUN: holds its previous value.
  - SHOW: result register.
  - ERR: 4'hE.
- Transitions (press pulse = p):
  - GET_A, p: alu_a ← din, go to GET_B.
  - GET_B, p: alu_b ← din, go to GET_OP.
  - GET_OP, p: alu_op ← din[1:0], go to RUN, timer ← 0. alu_start=1 during exactly the first RUN cycle.
  - RUN: p is ignored. alu_done is sampled starting the cycle after alu_start.
    - alu_done=1: result ← alu_result, go to SHOW.
    - Otherwise the timer increments. When timer == TIMEOUT_CYCLES-1 with no done, go to ERR and set err=1.
    - alu_done on the same cycle as the timeout: done wins, go to SHOW, err stays 0.
  - SHOW, p: go to GET_A. alu_a, alu_b and alu_op retain their values.
  - ERR, p: go to GET_A, err ← 0.
- alu_done is ignored outside RUN and on the alu_start cycle itself.
- alu_a, alu_b and alu_op remain stable from the alu_start cycle until the next press in SHOW or ERR.
- din changes never alter a captured register except on a press.

Test Plan:
1. Reset: assert rst_n=0 for 2 cycles with key_n=0 and din=4'h9, then release → all outputs 0, stage=0. No press is accepted until key_n has been high ≥4 cycles and then low ≥4 cycles.
2. Nominal operation, DEBOUNCE=4: din=5 press, din=3 press, din=2 press. Then alu_done=1 with alu_result=8 on the 3rd RUN cycle → alu_a=5, alu_b=3, alu_op=2, alu_start high exactly 1 cycle, stage=4 and aluout=8 one cycle after done. A further press → stage=0, aluout tracks din.
3. Bounce rejection: key_n low 2 cycles, high 1, low 3, high 10 → no press and stage unchanged. Then key_n low 6 cycles → exactly one press, stage 0→1 at cycle 2+4 after the fall.
4. Timeout, TIMEOUT=16: enter RUN and never assert alu_done → 16th RUN cycle transitions to stage=5, err=1, aluout=4'hE. Press → stage=0, err=0.
5. Races:
   - alu_done=1 with alu_result=4'hA on the same cycle the timeout would fire → stage=4, aluout=A, err=0.
   - alu_done pulses in GET_A and SHOW → no state or result change.
6. Reset mid-RUN at timer=7 → next cycle stage=0, alu_start=0, timer=0, alu_a/b/op=0. A subsequent full sequence operates normally.
